// File: rtl/run_ctrl_pkg.sv
// Shared types and helpers for the CPU run-control unit.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_STEP  = 2'd1,
    ST_RUN   = 2'd2
  } run_state_e;

  // Index width for the breakpoint file; a single register still needs one bit.
  function automatic int bp_idx_width(input int nbp);
    return (nbp <= 1) ? 1 : $clog2(nbp);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button filter: the level follows the raw input only after DB_CYC stable cycles,
// and a registered one-cycle pulse marks each accepted press.
module btn_debounce #(
  parameter int DB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int CNT_W = $clog2(DB_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;

  // cnt_q holds how many earlier consecutive cycles the raw input disagreed.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (raw != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = raw;
        pulse_d = raw;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/run_ctrl.sv
// CPU run control: debounced step/continue buttons drive a clock enable that is
// paused, issues N cycles, or free-runs until a PC breakpoint matches.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int NBP    = 4,
  parameter int STEP_W = 8,
  parameter int DB_CYC = 1_000_000
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          step,
  input  logic                          cont,
  input  logic [STEP_W-1:0]             step_n,
  input  logic                          bp_we,
  input  logic [bp_idx_width(NBP)-1:0]  bp_idx,
  input  logic [PC_W-1:0]               bp_addr,
  input  logic                          bp_en,
  input  logic [PC_W-1:0]               pc,
  output logic                          cpu_ce,
  output logic                          pause,
  output logic                          hit,
  output logic [bp_idx_width(NBP)-1:0]  hit_idx
);

  localparam int BP_IDX_W = bp_idx_width(NBP);

  logic step_lvl, step_pulse, cont_lvl, cont_pulse;
  logic step_p, cont_p;

  btn_debounce #(.DB_CYC(DB_CYC)) u_step_db (
    .clk   (clk),
    .rstn  (rstn),
    .raw   (step),
    .level (step_lvl),
    .pulse (step_pulse)
  );

  btn_debounce #(.DB_CYC(DB_CYC)) u_cont_db (
    .clk   (clk),
    .rstn  (rstn),
    .raw   (cont),
    .level (cont_lvl),
    .pulse (cont_pulse)
  );

  // A rising-edge pulse always coincides with a high filtered level.
  assign step_p = step_pulse & step_lvl;
  assign cont_p = cont_pulse & cont_lvl;

  logic [PC_W-1:0]     bp_addr_q [NBP];
  logic [PC_W-1:0]     bp_addr_d [NBP];
  logic [NBP-1:0]      bp_en_q, bp_en_d;

  always_comb begin
    bp_addr_d = bp_addr_q;
    bp_en_d   = bp_en_q;
    if (bp_we) begin
      for (int i = 0; i < NBP; i++) begin
        if (bp_idx == BP_IDX_W'(i)) begin
          bp_addr_d[i] = bp_addr;
          bp_en_d[i]   = bp_en;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NBP; i++) begin
        bp_addr_q[i] <= '0;
      end
      bp_en_q <= '0;
    end else begin
      bp_addr_q <= bp_addr_d;
      bp_en_q   <= bp_en_d;
    end
  end

  logic                match;
  logic [BP_IDX_W-1:0] match_idx;

  // Scanning downward leaves the lowest matching index in match_idx.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = NBP - 1; i >= 0; i--) begin
      if (bp_en_q[i] && (bp_addr_q[i] == pc)) begin
        match     = 1'b1;
        match_idx = BP_IDX_W'(i);
      end
    end
  end

  run_state_e          state_q, state_d;
  logic [STEP_W-1:0]   cnt_q, cnt_d;
  logic                skip_q, skip_d;
  logic                hit_q, hit_d;
  logic [BP_IDX_W-1:0] hit_idx_q, hit_idx_d;
  logic                pause_q, pause_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    skip_d    = skip_q;
    hit_d     = hit_q;
    hit_idx_d = hit_idx_q;
    cpu_ce    = 1'b0;
    case (state_q)
      ST_PAUSE: begin
        if (cont_p) begin
          state_d = ST_RUN;
          hit_d   = 1'b0;
          skip_d  = 1'b1;
        end else if (step_p) begin
          state_d = ST_STEP;
          cnt_d   = (step_n == '0) ? STEP_W'(1) : step_n;
          hit_d   = 1'b0;
        end
      end
      ST_STEP: begin
        cpu_ce = 1'b1;
        cnt_d  = cnt_q - STEP_W'(1);
        if (cnt_q <= STEP_W'(1)) begin
          state_d = ST_PAUSE;
        end
      end
      ST_RUN: begin
        // skip lets a resume execute the instruction sitting on a breakpoint.
        skip_d = 1'b0;
        if (match && !skip_q) begin
          state_d   = ST_PAUSE;
          hit_d     = 1'b1;
          hit_idx_d = match_idx;
        end else if (cont_p) begin
          state_d = ST_PAUSE;
        end else begin
          cpu_ce = 1'b1;
        end
      end
      default: begin
        state_d = ST_PAUSE;
      end
    endcase
    pause_d = (state_d == ST_PAUSE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_PAUSE;
      cnt_q     <= '0;
      skip_q    <= 1'b0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      pause_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      skip_q    <= skip_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
      pause_q   <= pause_d;
    end
  end

  assign pause   = pause_q;
  assign hit     = hit_q;
  assign hit_idx = hit_idx_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with a short debounce window and a toy PC model
// that advances by 4 on every enabled cycle.
module tb_run_ctrl;

  localparam int PC_W   = 32;
  localparam int NBP    = 4;
  localparam int STEP_W = 8;
  localparam int DB_CYC = 4;
  localparam int BPW    = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic              step_raw, cont_raw;
  logic [STEP_W-1:0] step_n;
  logic              bp_we;
  logic [BPW-1:0]    bp_idx;
  logic [PC_W-1:0]   bp_addr;
  logic              bp_en;
  logic [PC_W-1:0]   pc;
  logic              cpu_ce, pause, hit;
  logic [BPW-1:0]    hit_idx;

  logic              pc_clr, ce_clr;
  int unsigned       ce_cnt;
  int                compared = 0;
  int                mismatched = 0;

  always #5 clk = ~clk;

  run_ctrl #(
    .PC_W(PC_W), .NBP(NBP), .STEP_W(STEP_W), .DB_CYC(DB_CYC)
  ) dut (
    .clk(clk), .rstn(rstn), .step(step_raw), .cont(cont_raw), .step_n(step_n),
    .bp_we(bp_we), .bp_idx(bp_idx), .bp_addr(bp_addr), .bp_en(bp_en), .pc(pc),
    .cpu_ce(cpu_ce), .pause(pause), .hit(hit), .hit_idx(hit_idx)
  );

  // CPU stand-in: executes one instruction per enabled cycle.
  always @(posedge clk) begin
    if (pc_clr) pc <= '0;
    else if (cpu_ce) pc <= pc + 32'd4;
  end

  always @(posedge clk) begin
    if (ce_clr) ce_cnt <= 0;
    else if (cpu_ce) ce_cnt <= ce_cnt + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic s, input logic c, input int hold);
    step_raw = s;
    cont_raw = c;
    tick(hold);
    step_raw = 1'b0;
    cont_raw = 1'b0;
  endtask

  task automatic bp_write(input int idx, input logic [31:0] addr, input logic en);
    bp_we   = 1'b1;
    bp_idx  = BPW'(idx);
    bp_addr = addr;
    bp_en   = en;
    tick(1);
    bp_we   = 1'b0;
  endtask

  task automatic clear_ce;
    ce_clr = 1'b1;
    tick(1);
    ce_clr = 1'b0;
  endtask

  task automatic wait_pause(input string tag, input int budget);
    int k = 0;
    while (pause !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    check_output(tag, {31'd0, pause}, 32'd1);
  endtask

  task automatic wait_pc(input string tag, input logic [31:0] target, input int budget);
    int k = 0;
    while (pc !== target && k < budget) begin
      tick(1);
      k++;
    end
    check_output(tag, pc, target);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rstn = 1'b0; step_raw = 1'b0; cont_raw = 1'b0; step_n = 8'd1;
    bp_we = 1'b0; bp_idx = '0; bp_addr = '0; bp_en = 1'b0;
    pc_clr = 1'b1; ce_clr = 1'b1;

    // Reset held while buttons are active.
    tick(2);
    step_raw = 1'b1; cont_raw = 1'b1;
    tick(8);
    check_output("rst_ce", {31'd0, cpu_ce}, 32'd0);
    check_output("rst_pause", {31'd0, pause}, 32'd1);
    check_output("rst_hit", {31'd0, hit}, 32'd0);
    check_output("rst_hit_idx", {30'd0, hit_idx}, 32'd0);
    step_raw = 1'b0; cont_raw = 1'b0;
    rstn = 1'b1;
    tick(10);
    check_output("rel_pause", {31'd0, pause}, 32'd1);
    check_output("rel_ce", {31'd0, cpu_ce}, 32'd0);
    pc_clr = 1'b0; ce_clr = 1'b0;

    // Glitch shorter than the debounce window.
    press(1'b1, 1'b0, 3);
    tick(12);
    check_output("glitch_ce_cnt", ce_cnt, 32'd0);
    check_output("glitch_pause", {31'd0, pause}, 32'd1);

    // Single step.
    step_n = 8'd1;
    press(1'b1, 1'b0, 6);
    tick(15);
    check_output("step1_ce_cnt", ce_cnt, 32'd1);
    check_output("step1_pause", {31'd0, pause}, 32'd1);

    // Five-cycle step.
    step_n = 8'd5;
    clear_ce();
    press(1'b1, 1'b0, 6);
    tick(15);
    check_output("step5_ce_cnt", ce_cnt, 32'd5);
    check_output("step5_pause", {31'd0, pause}, 32'd1);

    // Zero step count behaves as one.
    step_n = 8'd0;
    clear_ce();
    press(1'b1, 1'b0, 6);
    tick(15);
    check_output("step0_ce_cnt", ce_cnt, 32'd1);

    // Two breakpoints on the same address: lowest index reported.
    bp_write(1, 32'h0C, 1'b1);
    bp_write(2, 32'h0C, 1'b1);
    pc_clr = 1'b1;
    tick(1);
    pc_clr = 1'b0;
    press(1'b0, 1'b1, 6);
    wait_pause("bp_stop_pause", 40);
    check_output("bp_stop_pc", pc, 32'h0C);
    check_output("bp_stop_hit", {31'd0, hit}, 32'd1);
    check_output("bp_stop_idx", {30'd0, hit_idx}, 32'd1);
    check_output("bp_stop_ce", {31'd0, cpu_ce}, 32'd0);
    tick(8);

    // Resume steps over the breakpoint it stopped on.
    press(1'b0, 1'b1, 6);
    tick(8);
    check_output("resume_run", {31'd0, pause}, 32'd0);
    check_output("resume_hit_clr", {31'd0, hit}, 32'd0);
    check_output("resume_past", {31'd0, (pc > 32'h0C)}, 32'd1);
    check_output("resume_ce", {31'd0, cpu_ce}, 32'd1);

    // Continue during RUN stops without flagging a hit.
    press(1'b0, 1'b1, 6);
    tick(8);
    check_output("cont_stop_pause", {31'd0, pause}, 32'd1);
    check_output("cont_stop_hit", {31'd0, hit}, 32'd0);
    check_output("cont_stop_ce", {31'd0, cpu_ce}, 32'd0);

    // Step and continue accepted together: continue wins.
    step_n = 8'd2;
    press(1'b1, 1'b1, 6);
    tick(15);
    check_output("both_run", {31'd0, pause}, 32'd0);
    press(1'b0, 1'b1, 6);
    tick(8);
    check_output("both_stop", {31'd0, pause}, 32'd1);

    // Breakpoint written while running.
    bp_write(1, 32'h0C, 1'b0);
    bp_write(2, 32'h0C, 1'b0);
    pc_clr = 1'b1;
    press(1'b0, 1'b1, 6);
    tick(3);
    check_output("dyn_running", {31'd0, pause}, 32'd0);
    pc_clr = 1'b0;
    wait_pc("dyn_pc10", 32'h10, 20);
    bp_write(0, 32'h20, 1'b1);
    wait_pause("dyn_stop_pause", 40);
    check_output("dyn_stop_pc", pc, 32'h20);
    check_output("dyn_stop_hit", {31'd0, hit}, 32'd1);
    check_output("dyn_stop_idx", {30'd0, hit_idx}, 32'd0);
    tick(8);

    // Disabled breakpoint does not stop the run.
    bp_write(0, 32'h20, 1'b0);
    pc_clr = 1'b1;
    press(1'b0, 1'b1, 6);
    tick(3);
    pc_clr = 1'b0;
    tick(20);
    check_output("dis_running", {31'd0, pause}, 32'd0);
    check_output("dis_past", {31'd0, (pc > 32'h20)}, 32'd1);
    press(1'b0, 1'b1, 6);
    tick(8);
    check_output("dis_stop", {31'd0, pause}, 32'd1);

    // Asynchronous reset in the middle of a long step.
    step_n = 8'd200;
    press(1'b1, 1'b0, 6);
    tick(3);
    check_output("long_step_ce", {31'd0, cpu_ce}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check_output("async_ce", {31'd0, cpu_ce}, 32'd0);
    check_output("async_pause", {31'd0, pause}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    tick(5);
    check_output("post_rst_pause", {31'd0, pause}, 32'd1);
    check_output("post_rst_ce", {31'd0, cpu_ce}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
